// File: rtl/fft16_bitrev_loader.sv
// fft16_bitrev_loader
//    Collects a 16-sample complex frame in arrival order, stores each sample at
//    its bit-reversed address, then presents the buffer as 8 consecutive pairs
//    (buffer[2p], buffer[2p+1]) for the first radix-2 butterfly stage.
//
//    Build option: define FFT_LOADER_SCALE_EN to store every re/im value
//    arithmetic-shifted right by 4 (guard headroom for 4 butterfly stages).
//    Without it, stored values equal input values bit-exactly.
//
// Parameters
//    N           data word width (two's complement)
//    Q           fractional bits; carried through only, no effect on data
// Ports
//    i_clk       clock, rising edge
//    i_rst       synchronous active-high reset
//    i_valid     upstream sample present
//    i_re, i_im  upstream sample
//    o_ready     loader accepts a sample this cycle (FILL)
//    o_valid     butterfly input pair presented (DRAIN)
//    i_ready     downstream consumes the presented pair
//    o_in0_*     buffer[2p]
//    o_in1_*     buffer[2p+1]
//    o_pair_idx  pair index p (0..7)
//    o_last      high while pair 7 is presented
module fft16_bitrev_loader #(
   parameter int N = 16,
   parameter int Q = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   input  logic [N-1:0] i_re,
   input  logic [N-1:0] i_im,
   output logic         o_ready,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_in0_re,
   output logic [N-1:0] o_in0_im,
   output logic [N-1:0] o_in1_re,
   output logic [N-1:0] o_in1_im,
   output logic [2:0]   o_pair_idx,
   output logic         o_last
);

`ifdef FFT_LOADER_SCALE_EN
   localparam int unsigned SHIFT = 4;
`else
   localparam int unsigned SHIFT = 0;
`endif

   // Q only describes the number format; reject a nonsensical setting.
   if (Q < 0 || Q >= N) begin : g_q_range
      $error("fft16_bitrev_loader: Q must lie in 0..N-1");
   end

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [2:0]  pair, pair_nx;
   logic        accept;
   logic        show;
   logic [3:0]  wr_addr;
   logic [N-1:0] wr_re, wr_im;

   logic [N-1:0] mem_re [16];
   logic [N-1:0] mem_im [16];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= FILL;
         cnt   <= '0;
         pair  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         pair  <= pair_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pair_nx  = pair;
      o_ready  = 1'b0;
      o_valid  = 1'b0;
      accept   = 1'b0;
      case (state)
         FILL: begin
            o_ready = 1'b1;
            if (i_valid) begin
               accept = 1'b1;
               cnt_nx = cnt + 4'd1;
               if (cnt == 4'd15) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            o_valid = !i_rst;
            if (i_ready) begin
               pair_nx = pair + 3'd1;
               if (pair == 3'd7) state_nx = FILL;
            end
         end
      endcase
   end

   // Outputs are forced to zero outside DRAIN and during reset, so buffer
   // contents from a discarded frame can never leak out.
   assign show    = (state == DRAIN) && !i_rst;
   assign wr_addr = {cnt[0], cnt[1], cnt[2], cnt[3]};
   assign wr_re   = $signed(i_re) >>> SHIFT;
   assign wr_im   = $signed(i_im) >>> SHIFT;

   always_ff @(posedge i_clk) begin
      if (accept && !i_rst) begin
         mem_re[wr_addr] <= wr_re;
         mem_im[wr_addr] <= wr_im;
      end
   end

   assign o_in0_re   = show ? mem_re[{pair, 1'b0}] : '0;
   assign o_in0_im   = show ? mem_im[{pair, 1'b0}] : '0;
   assign o_in1_re   = show ? mem_re[{pair, 1'b1}] : '0;
   assign o_in1_im   = show ? mem_im[{pair, 1'b1}] : '0;
   assign o_pair_idx = show ? pair : '0;
   assign o_last     = show && (pair == 3'd7);

endmodule

// File: tb/tb_fft16_bitrev_loader.sv
// tb_fft16_bitrev_loader
//    Scoreboard bench for fft16_bitrev_loader: each fed frame pushes its 8
//    expected pairs; the drain task pops and compares as pairs are consumed.
module tb_fft16_bitrev_loader;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic [15:0] i_re, i_im;
   logic        o_ready, o_valid, i_ready;
   logic [15:0] o_in0_re, o_in0_im, o_in1_re, o_in1_im;
   logic [2:0]  o_pair_idx;
   logic        o_last;

   typedef struct packed {
      logic [15:0] r0;
      logic [15:0] i0;
      logic [15:0] r1;
      logic [15:0] i1;
      logic [2:0]  idx;
      logic        last;
   } pair_t;

   pair_t       sb[$];
   logic [15:0] frame_re [16];
   logic [15:0] frame_im [16];
   int          n_checks = 0;
   int          n_fail   = 0;

   fft16_bitrev_loader #(.N(16), .Q(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_re(i_re), .i_im(i_im),
      .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
      .o_in0_re(o_in0_re), .o_in0_im(o_in0_im), .o_in1_re(o_in1_re), .o_in1_im(o_in1_im),
      .o_pair_idx(o_pair_idx), .o_last(o_last)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [3:0] bitrev4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   function automatic logic [15:0] sc(input logic [15:0] v);
`ifdef FFT_LOADER_SCALE_EN
      return $signed(v) >>> 4;
`else
      return v;
`endif
   endfunction

   task automatic set_ramp();
      for (int k = 0; k < 16; k++) begin
         frame_re[k] = 16'(k << 8);
         frame_im[k] = 16'h0000;
      end
   endtask

   task automatic set_random();
      for (int k = 0; k < 16; k++) begin
         frame_re[k] = 16'($urandom);
         frame_im[k] = 16'($urandom);
      end
   endtask

   // Feed nsamp samples; gaps inserts idle cycles. A complete frame pushes
   // its expected pairs and checks pair 0 is valid the very next cycle.
   task automatic feed_frame(input int nsamp, input bit gaps);
      pair_t e;
      logic [3:0] a0, a1;
      for (int k = 0; k < nsamp; k++) begin
         if (gaps && (k % 3 == 1)) begin
            i_valid = 1'b0;
            tick();
         end
         i_valid = 1'b1;
         i_re    = frame_re[k];
         i_im    = frame_im[k];
         n_checks++;
         if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_handshake k=%0d: o_ready=%b o_valid=%b, required 1/0", k, o_ready, o_valid);
         end
         tick();
      end
      i_valid = 1'b0;
      if (nsamp == 16) begin
         for (int p = 0; p < 8; p++) begin
            a0 = bitrev4(4'(2 * p));
            a1 = bitrev4(4'(2 * p + 1));
            e.r0 = sc(frame_re[a0]);
            e.i0 = sc(frame_im[a0]);
            e.r1 = sc(frame_re[a1]);
            e.i1 = sc(frame_im[a1]);
            e.idx = 3'(p);
            e.last = (p == 7);
            sb.push_back(e);
         end
         n_checks++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_pair_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_latency: o_valid=%b o_ready=%b idx=%0d, required 1/0/0", o_valid, o_ready, o_pair_idx);
         end
      end
   endtask

   // Consume npairs pairs. mode 0: i_ready always 1; mode 1: 1,0,0,1 pattern.
   // dirty drives i_valid with 0x7FFF throughout the drain.
   task automatic drain_frame(input int npairs, input int mode, input bit dirty);
      int    popped = 0;
      int    cyc = 0;
      bit    rdy, vld;
      pair_t act;
      while (popped < npairs && cyc < 100) begin
         rdy = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
         i_ready = rdy;
         if (dirty) begin
            i_valid = 1'b1;
            i_re    = 16'h7FFF;
            i_im    = 16'h7FFF;
         end
         vld = (o_valid === 1'b1);
         act = '{o_in0_re, o_in0_im, o_in1_re, o_in1_im, o_pair_idx, o_last};
         n_checks++;
         if (!vld || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_valid cyc=%0d: o_valid=%b o_ready=%b, required 1/0", cyc, o_valid, o_ready);
         end else if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL drain_extra: pair %h presented, required none", act);
         end else if (act !== sb[0]) begin
            n_fail++;
            $display("FAIL drain_pair cyc=%0d: got %h, required %h", cyc, act, sb[0]);
         end
         tick();
         if (rdy && vld) begin
            if (sb.size() > 0) void'(sb.pop_front());
            popped++;
         end
         cyc++;
      end
      i_ready = 1'b0;
      i_valid = 1'b0;
      if (popped < npairs) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pairs, required %0d", popped, npairs);
      end
      if (npairs == 8) begin
         n_checks++;
         if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_last !== 1'b0) begin
            n_fail++;
            $display("FAIL refill: o_ready=%b o_valid=%b o_last=%b, required 1/0/0", o_ready, o_valid, o_last);
         end
      end
   endtask

   task automatic check_idle(input string tag);
      n_checks++;
      if (o_valid !== 1'b0 || o_last !== 1'b0 || o_pair_idx !== 3'd0 ||
          {o_in0_re, o_in0_im, o_in1_re, o_in1_im} !== 64'h0) begin
         n_fail++;
         $display("FAIL %s: valid=%b last=%b idx=%0d in=%h_%h_%h_%h, required all zero",
                  tag, o_valid, o_last, o_pair_idx, o_in0_re, o_in0_im, o_in1_re, o_in1_im);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
      i_re = 16'h1234; i_im = 16'h5678;
      tick();
      check_idle("reset_during");
      tick();
      i_rst = 1'b0; i_valid = 1'b0;
      tick();
      check_idle("reset_after");
      n_checks++;
      if (o_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: o_ready=%b, required 1", o_ready);
      end
   endtask

   task automatic test_ramp();
      set_ramp();
      feed_frame(16, 1'b0);
`ifndef FFT_LOADER_SCALE_EN
      n_checks++;
      if (o_in0_re !== 16'h0000 || o_in1_re !== 16'h0800 || o_last !== 1'b0) begin
         n_fail++;
         $display("FAIL ramp_pair0: in0_re=%h in1_re=%h last=%b, required 0000/0800/0", o_in0_re, o_in1_re, o_last);
      end
`endif
      drain_frame(8, 0, 1'b0);
   endtask

   task automatic test_stall();
      set_random();
      feed_frame(16, 1'b1);
      drain_frame(8, 1, 1'b0);
   endtask

   task automatic test_drain_ignore();
      set_random();
      feed_frame(16, 1'b0);
      drain_frame(8, 1, 1'b1);
      set_random();
      feed_frame(16, 1'b0);
      drain_frame(8, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      set_random();
      feed_frame(9, 1'b0);
      i_rst = 1'b1; i_valid = 1'b1; i_re = 16'h7FFF; i_im = 16'h7FFF;
      tick();
      i_rst = 1'b0; i_valid = 1'b0;
      check_idle("reset_mid_fill");
      set_random();
      feed_frame(16, 1'b1);
      drain_frame(3, 0, 1'b0);
      i_rst = 1'b1; i_ready = 1'b1;
      #1;
      check_idle("reset_in_drain");
      tick();
      i_rst = 1'b0; i_ready = 1'b0;
      check_idle("reset_mid_drain");
      sb.delete();
      set_random();
      feed_frame(16, 1'b0);
      drain_frame(8, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         set_random();
         feed_frame(16, 1'b0);
         drain_frame(8, 0, 1'b0);
      end
   endtask

`ifdef FFT_LOADER_SCALE_EN
   task automatic test_scale();
      set_ramp();
      feed_frame(16, 1'b0);
      n_checks++;
      if (o_in1_re !== 16'h0080) begin
         n_fail++;
         $display("FAIL scale_pos: in1_re=%h, required 0080", o_in1_re);
      end
      drain_frame(8, 0, 1'b0);
      set_ramp();
      frame_re[8] = 16'hFF00;
      feed_frame(16, 1'b0);
      n_checks++;
      if (o_in1_re !== 16'hFFF0) begin
         n_fail++;
         $display("FAIL scale_neg: in1_re=%h, required FFF0", o_in1_re);
      end
      drain_frame(8, 0, 1'b0);
   endtask
`endif

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
      i_re = '0; i_im = '0;
      test_reset();
      test_ramp();
      test_stall();
      test_drain_ignore();
      test_reset_mid();
      test_back_to_back();
`ifdef FFT_LOADER_SCALE_EN
      test_scale();
`endif
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: %0d pairs left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft16_bitrev_loader.md
FFT16_BITREV_LOADER -- requirements
Module: fft16_bitrev_loader

Interface
REQ-001 SHALL have parameter N, default 16: data word width, two's complement.
REQ-002 SHALL have parameter Q, default 8: fractional bits; it is carried through only and does not change the arithmetic.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1 bit: an upstream sample is present.
REQ-006 SHALL have port i_re, input, N bits: real part of the sample.
REQ-007 SHALL have port i_im, input, N bits: imaginary part of the sample.
REQ-008 SHALL have port o_ready, output, 1 bit: the loader accepts a sample this cycle.
REQ-009 SHALL have port o_valid, output, 1 bit: a butterfly input pair is presented.
REQ-010 SHALL have port i_ready, input, 1 bit: the downstream butterfly consumes the pair.
REQ-011 SHALL have ports o_in0_re, o_in0_im, o_in1_re, o_in1_im, outputs, N bits each: the pair presented to the stage-1 radix-2 butterfly.
REQ-012 SHALL have port o_pair_idx, output, 3 bits: index 0..7 of the presented pair.
REQ-013 SHALL have port o_last, output, 1 bit: high while pair 7 is presented.

Function
REQ-014 SHALL implement two states, FILL and DRAIN; state is FILL after reset.
REQ-015 In FILL: o_ready=1 and o_valid=0; a sample is accepted on cycles where i_valid&&o_ready.
REQ-016 SHALL store accepted sample k (k=0..15, in arrival order) at buffer address bitrev4(k), i.e. address {k[0],k[1],k[2],k[3]}.
REQ-017 The 4-bit sample counter SHALL wrap to 0 on the 16th acceptance; the state SHALL become DRAIN on that same edge.
REQ-018 In DRAIN: o_ready=0, o_valid=1; any i_valid in this state SHALL be ignored and no sample stored.
REQ-019 Pair p SHALL present buffer[2p] on o_in0_* and buffer[2p+1] on o_in1_*, with o_pair_idx=p and o_last=(p==7).
REQ-020 Latency: o_valid SHALL be high, with pair 0 valid, in the first cycle after the 16th acceptance.
REQ-021 The pair SHALL advance only on o_valid&&i_ready; while i_ready=0 all o_in*, o_pair_idx and o_last SHALL be held stable.
REQ-022 A handshake on pair 7 SHALL return the state to FILL with the pair index at 0; o_ready SHALL be 1 in the next cycle.
REQ-023 i_valid gaps in FILL SHALL stall the counter without loss; i_ready gaps in DRAIN SHALL stall the pair index without loss.
REQ-024 When the feature of REQ-029 is not enabled, no arithmetic SHALL be applied: stored values equal input values bit-exactly.

Reset
REQ-025 When i_rst=1 at a clock edge, the state SHALL become FILL and the sample counter and pair index SHALL become 0.
REQ-026 During and after reset: o_valid=0, o_last=0, o_pair_idx=0, o_in*=0, o_ready=1 from the first cycle after reset.
REQ-027 Reset mid-FILL or mid-DRAIN SHALL discard the partial frame; buffer contents need not be cleared but SHALL never be presented before being rewritten.
REQ-028 i_rst SHALL take priority over a simultaneous handshake on the input or the output.

Configuration
REQ-029 Macro FFT_LOADER_SCALE_EN, when defined: every stored re/im value SHALL be arithmetic-shifted right by 4 (sign-preserving, truncation toward negative infinity) as guard headroom for the 4 butterfly stages.
REQ-030 Without FFT_LOADER_SCALE_EN the block SHALL be unscaled per REQ-024; latency and handshake SHALL be identical in both builds.

Verification
REQ-031 Test: reset, then x[k].re=k<<8, im=0 streamed back-to-back. Expected: pair0=(0x0000,0x0800), pair1=(0x0400,0x0C00), pair7=(0x0700,0x0F00), o_last only on pair 7.
REQ-032 Test: same frame with i_ready toggled 1,0,0,1,... Expected: outputs are held during the 0-cycles and all 8 pairs arrive in order, none dropped or repeated.
REQ-033 Test: i_valid asserted during DRAIN with value 0x7FFF. Expected: the value is not stored; the next frame's pair 0 shows only new-frame data.
REQ-034 Test: i_rst pulsed after 9 samples, then a full new frame. Expected: o_valid=0 until 16 new samples are accepted; pairs match the new frame only.
REQ-035 Test with FFT_LOADER_SCALE_EN defined: x[8].re=0x0800 gives o_in1_re=0x0080 on pair 0; x[8].re=0xFF00 gives 0xFFF0.
REQ-036 Test: pair-7 handshake followed by a sample on the very next cycle. Expected: o_ready=1 and the sample is accepted as k=0.
